// File: rtl/stopwatch_lap.sv
// MM:SS.hh stopwatch with up/down BCD counting, preset load and lap capture/recall.
// Feeds six BCD digits to the seven-segment decoders; all key inputs are single-cycle pulses.
module stopwatch_lap #(
   parameter int TICK_DIV  = 500000,
   parameter int LAP_DEPTH = 4
) (
   input  logic        clk,
   input  logic        key_reset,
   input  logic        start_pause,
   input  logic        clear,
   input  logic        lap,
   input  logic        lap_show,
   input  logic        count_down,
   input  logic        preset_load,
   input  logic [23:0] preset_bcd,
   output logic [23:0] display_bcd,
   output logic        running,
   output logic        done,
   output logic [3:0]  lap_count,
   output logic        lap_full,
   output logic        recall,
   output logic        tick
);

   localparam int PW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t        state;
   state_t        state_next;
   logic [23:0]   cur_time;
   logic [23:0]   tick_time;
   logic [PW-1:0] prescaler;
   logic          dir;
   logic [23:0]   lap_mem [LAP_DEPTH];
   logic [3:0]    show_idx;

   logic wrap;
   logic tick_now;
   logic hit_zero;
   logic act_preset;
   logic act_start;
   logic act_lap;
   logic act_show;

   // Digit 3 is the tens-of-seconds digit, the only one that tops out at 5.
   function automatic logic [3:0] digit_max(input int i);
      return (i == 3) ? 4'd5 : 4'd9;
   endfunction

   function automatic logic [23:0] bcd_inc(input logic [23:0] t);
      logic [23:0] r;
      logic        carry;
      r     = t;
      carry = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (carry) begin
            if (t[i*4 +: 4] >= digit_max(i)) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = t[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [23:0] bcd_dec(input logic [23:0] t);
      logic [23:0] r;
      logic        borrow;
      r      = t;
      borrow = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (borrow) begin
            if (t[i*4 +: 4] == 4'd0) begin
               r[i*4 +: 4] = digit_max(i);
            end else begin
               r[i*4 +: 4] = t[i*4 +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [23:0] bcd_clamp(input logic [23:0] t);
      logic [23:0] r;
      for (int i = 0; i < 6; i++) begin
         r[i*4 +: 4] = (t[i*4 +: 4] > digit_max(i)) ? digit_max(i) : t[i*4 +: 4];
      end
      return r;
   endfunction

   // Pulse arbitration: clear > preset_load > start_pause > lap; lap_show runs unless cleared.
   always_comb begin
      wrap       = (prescaler == PW'(TICK_DIV - 1));
      tick_now   = (state == RUN) && wrap && !clear;
      tick_time  = dir ? bcd_dec(cur_time) : bcd_inc(cur_time);
      hit_zero   = tick_now && dir && (tick_time == 24'h000000);
      act_preset = preset_load && (state == IDLE) && !clear;
      act_start  = start_pause && !clear && !act_preset && (state != DONE);
      act_lap    = lap && !clear && !act_preset && !act_start && !lap_full
                   && ((state == RUN) || (state == PAUSE));
      act_show   = lap_show && !clear && (lap_count != 4'd0);
   end

   always_ff @(posedge clk or negedge key_reset) begin
      if (!key_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (clear) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (act_start) begin
                  state_next = (count_down && (cur_time == 24'h000000)) ? DONE : RUN;
               end
            end
            RUN: begin
               if (hit_zero) begin
                  state_next = DONE;
               end else if (act_start) begin
                  state_next = PAUSE;
               end
            end
            PAUSE: begin
               if (act_start) begin
                  state_next = RUN;
               end
            end
            DONE: begin
               state_next = DONE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Prescaler only advances in RUN, so a pause keeps the partial hundredth.
   always_ff @(posedge clk or negedge key_reset) begin
      if (!key_reset) begin
         cur_time  <= 24'h000000;
         prescaler <= '0;
         dir       <= 1'b0;
         lap_count <= 4'd0;
         recall    <= 1'b0;
         show_idx  <= 4'd0;
         tick      <= 1'b0;
         for (int i = 0; i < LAP_DEPTH; i++) begin
            lap_mem[i] <= 24'h000000;
         end
      end else if (clear) begin
         cur_time  <= 24'h000000;
         prescaler <= '0;
         lap_count <= 4'd0;
         recall    <= 1'b0;
         show_idx  <= 4'd0;
         tick      <= 1'b0;
      end else begin
         tick <= tick_now;
         if (act_preset) begin
            cur_time <= bcd_clamp(preset_bcd);
         end else if (tick_now) begin
            cur_time <= tick_time;
         end
         if (state == RUN) begin
            prescaler <= wrap ? '0 : prescaler + PW'(1);
         end
         if ((state == IDLE) && act_start) begin
            dir <= count_down;
         end
         if (act_lap) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
               if (lap_count == 4'(i)) begin
                  lap_mem[i] <= cur_time;
               end
            end
            lap_count <= lap_count + 4'd1;
         end
         if (act_show) begin
            if (!recall) begin
               recall   <= 1'b1;
               show_idx <= 4'd0;
            end else if ((show_idx + 4'd1) == lap_count) begin
               recall   <= 1'b0;
               show_idx <= 4'd0;
            end else begin
               show_idx <= show_idx + 4'd1;
            end
         end
      end
   end

   always_comb begin
      running     = (state == RUN);
      done        = (state == DONE);
      lap_full    = (lap_count == 4'(LAP_DEPTH));
      display_bcd = cur_time;
      if (recall) begin
         for (int i = 0; i < LAP_DEPTH; i++) begin
            if (show_idx == 4'(i)) begin
               display_bcd = lap_mem[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap with a fast tick divider and a two-slot lap memory.
module tb_stopwatch_lap;

   logic        clk;
   logic        key_reset;
   logic        start_pause;
   logic        clear;
   logic        lap;
   logic        lap_show;
   logic        count_down;
   logic        preset_load;
   logic [23:0] preset_bcd;
   logic [23:0] display_bcd;
   logic        running;
   logic        done;
   logic [3:0]  lap_count;
   logic        lap_full;
   logic        recall;
   logic        tick;

   int total;
   int bad;

   typedef struct {
      logic        sp;
      logic        clr;
      logic        lp;
      logic        ls;
      logic        cd;
      logic        pl;
      logic [23:0] pbcd;
      logic [23:0] exp_disp;
      logic        exp_run;
      logic        exp_done;
      logic [3:0]  exp_lc;
      logic        exp_rec;
   } vec_t;

   vec_t vecs [6];

   stopwatch_lap #(
      .TICK_DIV  (4),
      .LAP_DEPTH (2)
   ) dut (
      .clk         (clk),
      .key_reset   (key_reset),
      .start_pause (start_pause),
      .clear       (clear),
      .lap         (lap),
      .lap_show    (lap_show),
      .count_down  (count_down),
      .preset_load (preset_load),
      .preset_bcd  (preset_bcd),
      .display_bcd (display_bcd),
      .running     (running),
      .done        (done),
      .lap_count   (lap_count),
      .lap_full    (lap_full),
      .recall      (recall),
      .tick        (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input logic sp, input logic clr, input logic lp, input logic ls);
      start_pause = sp;
      clear       = clr;
      lap         = lp;
      lap_show    = ls;
      step(1);
      start_pause = 1'b0;
      clear       = 1'b0;
      lap         = 1'b0;
      lap_show    = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      start_pause = v.sp;
      clear       = v.clr;
      lap         = v.lp;
      lap_show    = v.ls;
      count_down  = v.cd;
      preset_load = v.pl;
      preset_bcd  = v.pbcd;
      step(1);
      start_pause = 1'b0;
      clear       = 1'b0;
      lap         = 1'b0;
      lap_show    = 1'b0;
      preset_load = 1'b0;
   endtask

   task automatic checkState(input string name, input logic [23:0] disp,
                             input logic run, input logic dn, input logic [3:0] lc);
      checkOutput({name, ".display"}, 32'(display_bcd), 32'(disp));
      checkOutput({name, ".running"}, 32'(running), 32'(run));
      checkOutput({name, ".done"}, 32'(done), 32'(dn));
      checkOutput({name, ".lap_count"}, 32'(lap_count), 32'(lc));
   endtask

   initial begin
      int ticks_seen;
      total       = 0;
      bad         = 0;
      key_reset   = 1'b0;
      start_pause = 1'b0;
      clear       = 1'b0;
      lap         = 1'b0;
      lap_show    = 1'b0;
      count_down  = 1'b0;
      preset_load = 1'b0;
      preset_bcd  = 24'h000000;

      // Table of IDLE-state single-cycle operations.
      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h976ABC, 24'h975999, 1'b0, 1'b0, 4'd0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h123456, 24'h123456, 1'b0, 1'b0, 4'd0, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h123456, 1'b0, 1'b0, 4'd0, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h123456, 1'b0, 1'b0, 4'd0, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, 24'h000000, 1'b0, 1'b0, 4'd0, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 4'd0, 1'b0};

      #12;
      checkState("reset", 24'h000000, 1'b0, 1'b0, 4'd0);
      checkOutput("reset.lap_full", 32'(lap_full), 32'd0);
      checkOutput("reset.recall", 32'(recall), 32'd0);
      checkOutput("reset.tick", 32'(tick), 32'd0);
      key_reset = 1'b1;
      step(1);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i]);
         checkState($sformatf("vec%0d", i), vecs[i].exp_disp, vecs[i].exp_run,
                    vecs[i].exp_done, vecs[i].exp_lc);
         checkOutput($sformatf("vec%0d.recall", i), 32'(recall), 32'(vecs[i].exp_rec));
      end

      // Up count: first tick, 400-cycle value, pause hold and resume.
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      checkState("run_entry", 24'h000000, 1'b1, 1'b0, 4'd0);
      step(3);
      checkOutput("pre_first_tick", 32'(tick), 32'd0);
      step(1);
      checkOutput("first_tick", 32'(tick), 32'd1);
      checkOutput("first_tick.display", 32'(display_bcd), 32'h000001);
      step(396);
      checkOutput("400_cycles", 32'(display_bcd), 32'h000100);
      step(2);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      step(20);
      checkState("paused", 24'h000100, 1'b0, 1'b0, 4'd0);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("resume.tick", 32'(tick), 32'd0);
      checkOutput("resume.running", 32'(running), 32'd1);
      step(1);
      checkOutput("resume_tick", 32'(tick), 32'd1);
      checkOutput("resume_tick.display", 32'(display_bcd), 32'h000101);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      checkState("clear1", 24'h000000, 1'b0, 1'b0, 4'd0);

      // Lap capture, overflow and recall.
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      step(20);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("lap1.count", 32'(lap_count), 32'd1);
      step(15);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("lap3.count", 32'(lap_count), 32'd2);
      checkOutput("lap3.full", 32'(lap_full), 32'd1);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("show1.display", 32'(display_bcd), 32'h000005);
      checkOutput("show1.recall", 32'(recall), 32'd1);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("show2.display", 32'(display_bcd), 32'h000009);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("show3.display", 32'(display_bcd), 32'h000010);
      checkOutput("show3.recall", 32'(recall), 32'd0);

      // Coincident clear, start_pause and lap in RUN.
      pulse(1'b1, 1'b1, 1'b1, 1'b0);
      checkState("combo_clear", 24'h000000, 1'b0, 1'b0, 4'd0);
      checkOutput("combo_clear.full", 32'(lap_full), 32'd0);
      step(5);
      checkOutput("idle_hold", 32'(display_bcd), 32'h000000);

      // Up-count wrap from 99:59.99.
      preset_bcd  = 24'h995998;
      preset_load = 1'b1;
      step(1);
      preset_load = 1'b0;
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      step(4);
      checkOutput("wrap_pre", 32'(display_bcd), 32'h995999);
      step(4);
      checkState("wrap", 24'h000000, 1'b1, 1'b0, 4'd0);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);

      // Down count to terminal zero.
      preset_bcd  = 24'h000003;
      preset_load = 1'b1;
      step(1);
      preset_load = 1'b0;
      count_down  = 1'b1;
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      count_down  = 1'b0;
      step(8);
      checkState("down_1", 24'h000001, 1'b1, 1'b0, 4'd0);
      step(4);
      checkState("down_zero", 24'h000000, 1'b0, 1'b1, 4'd0);
      checkOutput("down_zero.tick", 32'(tick), 32'd1);
      step(6);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      checkState("done_hold", 24'h000000, 1'b0, 1'b1, 4'd0);
      checkOutput("done_hold.tick", 32'(tick), 32'd0);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      checkState("done_clear", 24'h000000, 1'b0, 1'b0, 4'd0);
      count_down = 1'b1;
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      count_down = 1'b0;
      checkState("down_from_zero", 24'h000000, 1'b0, 1'b1, 4'd0);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset between clock edges while running.
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      step(8);
      checkOutput("pre_reset.tick", 32'(tick), 32'd1);
      #2;
      key_reset = 1'b0;
      #1;
      checkState("async_reset", 24'h000000, 1'b0, 1'b0, 4'd0);
      checkOutput("async_reset.tick", 32'(tick), 32'd0);
      #1;
      key_reset  = 1'b1;
      ticks_seen = 0;
      for (int k = 0; k < 10; k++) begin
         step(1);
         if (tick) ticks_seen++;
      end
      checkOutput("post_reset.ticks", 32'(ticks_seen), 32'd0);
      checkState("post_reset", 24'h000000, 1'b0, 1'b0, 4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
